jstk2_led_spi: RTL

- Downstream stage of the colour-select logic: takes the 24-bit {red, green, blue} colour word and transmits it to the PmodJSTK2 as the 5-byte "set LED RGB" SPI command (0x84, R, G, B, 0x00).
- Captures the 5 bytes the JSTK2 returns in the same frame and presents them as joystick X/Y position and button state.
- Owns the JSTK2 SPI pins (ss_n, sclk, mosi, miso) on the ICEStick, running from the 12 MHz board clock.

---
 rtl/jstk2_led_spi_if.sv | 25 ++
 rtl/jstk2_led_spi.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/jstk2_led_spi_if.sv
// Signal bundle between the colour-select logic, the JSTK2 SPI pins and the
// joystick consumers; master is the jstk2_led_spi side.
interface jstk2_led_spi_if;
    logic [23:0] color_in;
    logic        start;
    logic        busy;
    logic        done;
    logic        ss_n;
    logic        sclk;
    logic        mosi;
    logic        miso;
    logic [9:0]  joy_x;
    logic [9:0]  joy_y;
    logic [1:0]  joy_btn;

    modport master (
        input  color_in, start, miso,
        output busy, done, ss_n, sclk, mosi, joy_x, joy_y, joy_btn
    );

    modport slave (
        output color_in, start, miso,
        input  busy, done, ss_n, sclk, mosi, joy_x, joy_y, joy_btn
    );
endinterface

// File: rtl/jstk2_led_spi.sv
// Sends the 5-byte JSTK2 "set LED RGB" command (0x84, R, G, B, 0x00) over SPI mode 0
// and captures the joystick position/button reply returned in the same frame.
module jstk2_led_spi #(
    parameter int unsigned SCLK_HALF    = 6,
    parameter int unsigned SS_SETUP_CYC = 180,
    parameter int unsigned BYTE_GAP_CYC = 120,
    parameter int unsigned SS_HOLD_CYC  = 300
) (
    input logic             clk,
    input logic             rst_n,
    jstk2_led_spi_if.master bus
);
    typedef enum logic [2:0] {StIdle, StSetup, StShift, StGap, StHold} state_e;

    localparam logic [8:0] SetupLoad = 9'(SS_SETUP_CYC - 1);
    localparam logic [8:0] GapLoad   = 9'(BYTE_GAP_CYC - 1);
    localparam logic [8:0] HoldLoad  = 9'(SS_HOLD_CYC - 1);
    localparam logic [8:0] HalfLoad  = 9'(SCLK_HALF - 1);

    state_e      state_q, state_d;
    logic [8:0]  cnt_q, cnt_d;
    logic [2:0]  bit_q, bit_d;
    logic [2:0]  byte_q, byte_d;
    logic        sclk_q, sclk_d;
    logic        ss_n_q, ss_n_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [39:0] tx_q, tx_d;
    logic [39:0] rx_q, rx_d;
    logic [9:0]  joy_x_q, joy_x_d;
    logic [9:0]  joy_y_q, joy_y_d;
    logic [1:0]  joy_btn_q, joy_btn_d;
    logic        miso_s1_q, miso_s2_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        byte_d    = byte_q;
        sclk_d    = sclk_q;
        ss_n_d    = ss_n_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        tx_d      = tx_q;
        rx_d      = rx_q;
        joy_x_d   = joy_x_q;
        joy_y_d   = joy_y_q;
        joy_btn_d = joy_btn_q;

        case (state_q)
            StIdle: begin
                // Holding start high restarts one cycle after done, never in the done cycle.
                if (bus.start && !done_q) begin
                    tx_d    = {8'h84, bus.color_in, 8'h00};
                    rx_d    = '0;
                    cnt_d   = SetupLoad;
                    bit_d   = 3'd0;
                    byte_d  = 3'd0;
                    ss_n_d  = 1'b0;
                    busy_d  = 1'b1;
                    state_d = StSetup;
                end
            end
            StSetup, StGap: begin
                if (cnt_q == 9'd0) begin
                    cnt_d   = HalfLoad;
                    state_d = StShift;
                end else begin
                    cnt_d = cnt_q - 9'd1;
                end
            end
            StShift: begin
                if (cnt_q != 9'd0) begin
                    cnt_d = cnt_q - 9'd1;
                end else if (!sclk_q) begin
                    sclk_d = 1'b1;
                    cnt_d  = HalfLoad;
                    rx_d   = {rx_q[38:0], miso_s2_q};
                end else begin
                    // Falling edge: mosi (tx_q[39]) moves on to the next bit.
                    sclk_d = 1'b0;
                    tx_d   = {tx_q[38:0], 1'b0};
                    bit_d  = bit_q + 3'd1;
                    if (bit_q != 3'd7) begin
                        cnt_d = HalfLoad;
                    end else if (byte_q == 3'd4) begin
                        ss_n_d  = 1'b1;
                        cnt_d   = HoldLoad;
                        state_d = StHold;
                    end else begin
                        byte_d  = byte_q + 3'd1;
                        cnt_d   = GapLoad;
                        state_d = StGap;
                    end
                end
            end
            StHold: begin
                if (cnt_q == 9'd0) begin
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    joy_x_d   = {rx_q[25:24], rx_q[39:32]};
                    joy_y_d   = {rx_q[9:8], rx_q[23:16]};
                    joy_btn_d = rx_q[1:0];
                    state_d   = StIdle;
                end else begin
                    cnt_d = cnt_q - 9'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            bit_q     <= '0;
            byte_q    <= '0;
            sclk_q    <= 1'b0;
            ss_n_q    <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            tx_q      <= '0;
            rx_q      <= '0;
            joy_x_q   <= '0;
            joy_y_q   <= '0;
            joy_btn_q <= '0;
            miso_s1_q <= 1'b0;
            miso_s2_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            byte_q    <= byte_d;
            sclk_q    <= sclk_d;
            ss_n_q    <= ss_n_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
            joy_x_q   <= joy_x_d;
            joy_y_q   <= joy_y_d;
            joy_btn_q <= joy_btn_d;
            miso_s1_q <= bus.miso;
            miso_s2_q <= miso_s1_q;
        end
    end

    // tx_q is all zeros once the last byte has shifted out, so mosi idles low.
    assign bus.mosi    = tx_q[39];
    assign bus.sclk    = sclk_q;
    assign bus.ss_n    = ss_n_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.joy_x   = joy_x_q;
    assign bus.joy_y   = joy_y_q;
    assign bus.joy_btn = joy_btn_q;
endmodule
